// File: rtl/dataflow_ctrl_pkg.sv
// Shared definitions for dataflow start-token controllers.
//   fsm_state_t          : consumer FSM states (IDLE waits for a token, START
//                          holds ap_start until the PE accepts it)
//   DEFAULT_MAX_INFLIGHT : default bound on started-but-not-done invocations
//   DEFAULT_INFL_W       : default width of the in-flight counter
//   DEFAULT_CNT_W        : default width of the completion counter
//   infl_width()         : minimum counter width able to hold a given bound
package dataflow_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        START = 1'b1
    } fsm_state_t;

    localparam int DEFAULT_MAX_INFLIGHT = 2;
    localparam int DEFAULT_INFL_W       = 3;
    localparam int DEFAULT_CNT_W        = 32;

    // Bits needed to represent 0..max_inflight inclusive.
    function automatic int infl_width(input int max_inflight);
        return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/start_fifo_consumer_inflight_tracker.sv
// Bookkeeping for PE invocations launched by start_fifo_consumer.
//   clk, reset        : clock, async active-high reset
//   inc               : a start was accepted this cycle (ap_start & ap_ready)
//   pe_ap_done        : PE reports one finished invocation
//   inflight          : started-not-done count
//   pe_ap_continue    : registered acknowledge, high while work is outstanding
//   done_count        : completions since reset, wraps silently
//   err_spurious_done : sticky, done seen with nothing outstanding
module inflight_tracker
    import dataflow_ctrl_pkg::*;
#(
    parameter int INFL_W = DEFAULT_INFL_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              pe_ap_done,
    output logic [INFL_W-1:0] inflight,
    output logic              pe_ap_continue,
    output logic [CNT_W-1:0]  done_count,
    output logic              err_spurious_done
);

    logic              accept_done;
    logic              spurious;
    logic [INFL_W-1:0] inflight_next;

    // A done is honoured when an invocation is outstanding, or when the start
    // is being accepted in the same cycle (ready-then-done within one cycle).
    assign accept_done = pe_ap_done && (pe_ap_continue || inc);
    assign spurious    = pe_ap_done && !pe_ap_continue && !inc;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        inflight_next = inflight;
        if (inc && !accept_done) begin
            inflight_next = inflight + INFL_W'(1);
        end else if (!inc && accept_done) begin
            inflight_next = inflight - INFL_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together on the edge regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight          <= '0;
            pe_ap_continue    <= 1'b0;
            done_count        <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            inflight       <= inflight_next;
            pe_ap_continue <= (inflight_next != '0);
            if (accept_done) begin
                done_count <= done_count + CNT_W'(1);
            end
            if (spurious) begin
                err_spurious_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/start_fifo_consumer.sv
// Read-side controller for a dataflow start-token FIFO. Pops one token per
// PE invocation, drives the PE ap_start/ap_ready/ap_done/ap_continue
// handshake, bounds in-flight invocations and counts completions.
//   clk, reset        : clock, async active-high reset
//   fifo_empty_n      : start FIFO holds a token
//   fifo_read         : combinational pop strobe to the FIFO
//   pe_ap_start       : registered PE start request
//   pe_ap_ready       : PE accepted the start
//   pe_ap_done        : PE finished one invocation
//   pe_ap_continue    : registered completion acknowledge
//   inflight          : started-not-done count
//   done_count        : completions since reset
//   busy              : FSM active or invocations outstanding
//   err_spurious_done : sticky, unexpected done observed
module start_fifo_consumer
    import dataflow_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT,
    parameter int INFL_W       = DEFAULT_INFL_W,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty_n,
    output logic              fifo_read,
    output logic              pe_ap_start,
    input  logic              pe_ap_ready,
    input  logic              pe_ap_done,
    output logic              pe_ap_continue,
    output logic [INFL_W-1:0] inflight,
    output logic [CNT_W-1:0]  done_count,
    output logic              busy,
    output logic              err_spurious_done
);

    fsm_state_t state;
    fsm_state_t state_next;
    logic       start_accept;

    // Gated by reset so no pop is issued while the block is held in reset.
    assign fifo_read = !reset && (state == IDLE) && fifo_empty_n &&
                       (inflight < INFL_W'(MAX_INFLIGHT));

    assign start_accept = (state == START) && pe_ap_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fifo_read)    state_next = START;
            START:   if (start_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: asynchronous reset appears in the sensitivity list so pe_ap_start
    // drops immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pe_ap_start <= 1'b0;
        end else begin
            state       <= state_next;
            pe_ap_start <= (state_next == START);
        end
    end

    inflight_tracker #(
        .INFL_W (INFL_W),
        .CNT_W  (CNT_W)
    ) u_tracker (
        .clk               (clk),
        .reset             (reset),
        .inc               (start_accept),
        .pe_ap_done        (pe_ap_done),
        .inflight          (inflight),
        .pe_ap_continue    (pe_ap_continue),
        .done_count        (done_count),
        .err_spurious_done (err_spurious_done)
    );

    assign busy = (state != IDLE) || (inflight != '0);

endmodule

// File: tb/tb_start_fifo_consumer.sv
module tb_start_fifo_consumer;

    localparam int MAX = 2;

    logic        clk;
    logic        reset;
    logic        fifo_empty_n;
    logic        fifo_read;
    logic        pe_ap_start;
    logic        pe_ap_ready;
    logic        pe_ap_done;
    logic        pe_ap_continue;
    logic [2:0]  inflight;
    logic [31:0] done_count;
    logic        busy;
    logic        err_spurious_done;

    start_fifo_consumer #(
        .MAX_INFLIGHT (MAX),
        .INFL_W       (3),
        .CNT_W        (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_empty_n      (fifo_empty_n),
        .fifo_read         (fifo_read),
        .pe_ap_start       (pe_ap_start),
        .pe_ap_ready       (pe_ap_ready),
        .pe_ap_done        (pe_ap_done),
        .pe_ap_continue    (pe_ap_continue),
        .inflight          (inflight),
        .done_count        (done_count),
        .busy              (busy),
        .err_spurious_done (err_spurious_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit start;
        int infl;
        int done;
        bit cont;
        bit err;
        bit busy;
    } exp_t;

    exp_t sb[$];
    int   due[$];

    int vectors = 0;
    int errors  = 0;
    int tokens  = 0;
    int pops    = 0;
    int handshakes   = 0;
    int start_cycles = 0;
    int cyc     = 0;
    bit auto_done = 1'b0;

    // Reference model state
    bit m_st   = 1'b0;
    int m_infl = 0;
    int m_done = 0;
    bit m_err  = 1'b0;

    int p0, s0, h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_tokens(input int n);
        tokens       = n;
        fifo_empty_n = (tokens > 0);
    endtask

    // One clock cycle: predict/compare the combinational pop before the edge,
    // push the predicted registered outputs, compare them after the edge.
    task automatic tick();
        exp_t e;
        bit   rd, hs, acc;
        @(negedge clk);
        rd = !reset && !m_st && (tokens > 0) && (m_infl < MAX);
        check("fifo_read", fifo_read, rd);
        if (fifo_read === 1'b1 && tokens > 0) begin
            tokens--;
            pops++;
        end
        if (pe_ap_start === 1'b1) begin
            start_cycles++;
            if (pe_ap_ready) begin
                handshakes++;
                if (auto_done) due.push_back(cyc + 4);
            end
        end
        hs  = m_st && pe_ap_ready;
        acc = pe_ap_done && ((m_infl != 0) || hs);
        if (reset) begin
            m_st = 1'b0; m_infl = 0; m_done = 0; m_err = 1'b0;
            due.delete();
        end else begin
            if (pe_ap_done && !acc) m_err = 1'b1;
            m_infl = m_infl + int'(hs) - int'(acc);
            m_done = m_done + int'(acc);
            if (rd) m_st = 1'b1;
            else if (hs) m_st = 1'b0;
        end
        e.start = m_st;
        e.infl  = m_infl;
        e.done  = m_done;
        e.cont  = (m_infl != 0);
        e.err   = m_err;
        e.busy  = m_st || (m_infl != 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("pe_ap_start", pe_ap_start, e.start);
            check("inflight", inflight, e.infl);
            check("done_count", done_count, e.done);
            check("pe_ap_continue", pe_ap_continue, e.cont);
            check("err_spurious_done", err_spurious_done, e.err);
            check("busy", busy, e.busy);
        end
        fifo_empty_n = (tokens > 0);
        pe_ap_done   = 1'b0;
        if (due.size() > 0 && due[0] <= cyc) begin
            pe_ap_done = 1'b1;
            void'(due.pop_front());
        end
    endtask

    initial begin
        // 1. Reset with a token waiting
        reset       = 1'b1;
        pe_ap_ready = 1'b1;
        pe_ap_done  = 1'b0;
        auto_done   = 1'b1;
        set_tokens(1);
        #1;
        check("rst_fifo_read", fifo_read, 0);
        check("rst_pe_ap_start", pe_ap_start, 0);
        check("rst_inflight", inflight, 0);
        check("rst_done_count", done_count, 0);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("post_rst_fifo_read", fifo_read, 1);
        tick();
        check("post_rst_start", pe_ap_start, 1);

        // 2. Three tokens, PE ready at once, done four cycles later
        set_tokens(tokens + 2);
        repeat (30) tick();
        check("t2_pops", pops, 3);
        check("t2_handshakes", handshakes, 3);
        check("t2_done_count", done_count, 3);
        check("t2_inflight", inflight, 0);
        check("t2_busy", busy, 0);

        // 3. In-flight bound with dones withheld
        auto_done = 1'b0;
        p0 = pops;
        set_tokens(5);
        repeat (12) tick();
        check("t3_pops_capped", pops - p0, 2);
        check("t3_inflight_max", inflight, 2);
        check("t3_fifo_read_held", fifo_read, 0);
        pe_ap_done = 1'b1;
        tick();
        repeat (6) tick();
        check("t3_one_more_pop", pops - p0, 3);
        check("t3_inflight_refill", inflight, 2);

        set_tokens(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // 4. PE stalls ready for six cycles
        pe_ap_ready = 1'b0;
        set_tokens(2);
        p0 = pops;
        s0 = start_cycles;
        tick();
        repeat (6) tick();
        check("t4_start_held", start_cycles - s0, 6);
        check("t4_no_extra_pop", pops - p0, 1);
        check("t4_inflight_wait", inflight, 0);
        check("t4_start_high", pe_ap_start, 1);
        pe_ap_ready = 1'b1;
        tick();
        check("t4_start_window", start_cycles - s0, 7);
        check("t4_inflight_after", inflight, 1);
        check("t4_start_low", pe_ap_start, 0);

        // 5. Ready with completion in one cycle, then spurious done
        pe_ap_ready = 1'b0;
        tick();
        pe_ap_ready = 1'b1;
        pe_ap_done  = 1'b1;
        tick();
        check("t5_inflight_same", inflight, 1);
        check("t5_done_inc", done_count, 1);
        pe_ap_done = 1'b1;
        tick();
        check("t5_drain_inflight", inflight, 0);
        check("t5_drain_done", done_count, 2);
        pe_ap_ready = 1'b0;
        set_tokens(1);
        tick();
        pe_ap_ready = 1'b1;
        pe_ap_done  = 1'b1;
        tick();
        check("t5_ready_then_done_infl", inflight, 0);
        check("t5_ready_then_done_cnt", done_count, 3);
        check("t5_no_err_yet", err_spurious_done, 0);
        pe_ap_done = 1'b1;
        tick();
        check("t5_spurious_err", err_spurious_done, 1);
        check("t5_spurious_cnt", done_count, 3);
        tick();
        check("t5_err_sticky", err_spurious_done, 1);

        // 6. Reset asserted mid-START with one invocation outstanding
        pe_ap_ready = 1'b1;
        set_tokens(2);
        tick();
        tick();
        pe_ap_ready = 1'b0;
        tick();
        check("t6_in_start", pe_ap_start, 1);
        check("t6_inflight_one", inflight, 1);
        #1 reset = 1'b1;
        #1;
        check("t6_async_start", pe_ap_start, 0);
        check("t6_async_inflight", inflight, 0);
        check("t6_async_done", done_count, 0);
        check("t6_async_err", err_spurious_done, 0);
        check("t6_async_busy", busy, 0);
        tick();
        reset = 1'b0;
        pe_ap_ready = 1'b1;
        set_tokens(1);
        h0 = handshakes;
        repeat (4) tick();
        check("t6_resume_hs", handshakes - h0, 1);
        check("t6_resume_inflight", inflight, 1);
        check("t6_resume_done", done_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/start_fifo_consumer.md
Name: start_fifo_consumer

Overview:
Read-side controller for a dataflow start-token FIFO (SRL-backed, width 1). It pops one start token per downstream PE invocation and drives the PE's ap_start/ap_ready/ap_done/ap_continue handshake. It bounds the number of in-flight invocations and counts completions. It sits between a start_for_* FIFO instance and the PE_* U0 it launches.

Parameters:
MAX_INFLIGHT, 2, maximum started-but-not-done PE invocations (1..7)
INFL_W, 3, width of the in-flight counter; must hold MAX_INFLIGHT
CNT_W, 32, width of the completion counter

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
fifo_empty_n  in  1  start FIFO holds at least one token
fifo_read  out  1  pop strobe to start FIFO (one token per cycle high)
pe_ap_start  out  1  PE start request
pe_ap_ready  in  1  PE accepted the start (sampled only while pe_ap_start=1)
pe_ap_done  in  1  PE finished one invocation
pe_ap_continue  out  1  completion acknowledge to PE
inflight  out  INFL_W  current started-not-done count
done_count  out  CNT_W  total completions since reset, wraps modulo 2^CNT_W
busy  out  1  state!=IDLE or inflight!=0
err_spurious_done  out  1  sticky: pe_ap_done seen with inflight==0 and no same-cycle ready

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; pe_ap_start=0; pe_ap_continue=0; inflight=0; done_count=0; err_spurious_done=0; fifo_read=0 from the next combinational evaluation. Reset mid-invocation abandons the token; the FIFO is not refilled.
- FSM states: IDLE and START.
- fifo_read is combinational: fifo_read = (state==IDLE) && fifo_empty_n && (inflight < MAX_INFLIGHT). It is never high in START.
- IDLE -> START on a cycle with fifo_read=1. pe_ap_start is registered and rises on that same edge.
- START: pe_ap_start holds at 1 until a cycle with pe_ap_ready=1. On that edge: pe_ap_start<=0, state<=IDLE, inflight increments.
- Pop-to-start latency is 1 cycle. Minimum token period is 2 cycles: pop, then start/ready. Back-to-back tokens therefore give fifo_read high every 2nd cycle at best.
- Completion: pe_ap_continue is registered and equals (next inflight != 0), so it is high whenever an invocation is outstanding. A completion is a cycle with pe_ap_done=1 and pe_ap_continue=1. On a completion, inflight decrements and done_count increments.
- Simultaneous ready and completion in one cycle: inflight is unchanged and done_count still increments.
- pe_ap_done with inflight==0: if pe_ap_ready is high in the same START cycle, treat it as ready-then-done, so the net inflight change is 0 and done_count increments. Otherwise the done is ignored and err_spurious_done is set (sticky until reset).
- inflight==MAX_INFLIGHT: no pop. The FSM stays in IDLE until a completion frees a slot. A pop is allowed in the cycle after the decrement takes effect; the same-cycle comparison uses the registered inflight.
- fifo_empty_n falling while in START has no effect, since the token was already taken.
- fifo_empty_n is never sampled outside IDLE.
- done_count wraps from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package (dataflow_ctrl_pkg): FSM state typedef {IDLE, START}, default MAX_INFLIGHT, CNT_W constants, and a clog2-based INFL_W helper.
- One natural sub-module: inflight_tracker. It holds the up/down counter with saturation-free inc/dec, the done_count accumulator and the spurious-done flag. The FSM stays in the top module.

Test Plan:
1. Reset with fifo_empty_n=1 -> fifo_read=0, pe_ap_start=0, inflight=0, done_count=0. After release, fifo_read=1 in the first cycle and pe_ap_start=1 at the next edge.
2. 3 tokens queued; PE ready same cycle as start, done 4 cycles later -> exactly 3 fifo_read pulses and 3 pe_ap_start windows. done_count ends at 3, inflight ends at 0, busy=0.
3. MAX_INFLIGHT=2; PE ready immediately, done withheld; 5 tokens queued -> only 2 pops, inflight=2, fifo_read held 0. One done then gives exactly one more pop.
4. PE holds pe_ap_ready=0 for 6 cycles in START -> pe_ap_start stays 1 for 7 cycles, no further fifo_read, inflight unchanged until ready.
5. pe_ap_ready and a completion in the same cycle with inflight=1 -> inflight stays 1, done_count +1. A lone pe_ap_done with inflight=0 -> err_spurious_done=1, done_count unchanged.
6. Assert reset in START with inflight=1 -> pe_ap_start falls without waiting for a clock edge and all counters read 0. Operation resumes normally with a fresh token after release.
